// File: rtl/alu_mul_sequencer.sv
// Issue-port controller for a shared alu32: passes single-cycle ops straight
// through and sequences a full NxN multiply from (N/2)x(N/2) MUL, ADD and SLL passes.
module alu_mul_sequencer #(
  parameter int unsigned N           = 32,
  parameter logic [3:0]  OP_MUL_FULL = 4'b0111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_y
);

  localparam int unsigned H = N / 2;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_HMUL = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    M_LL   = 3'd2,
    M_LH   = 3'd3,
    M_HL   = 3'd4,
    M_ADD1 = 3'd5,
    M_SHL  = 3'd6,
    M_ADD2 = 3'd7
  } state_t;

  state_t       state;
  logic [N-1:0] ra;
  logic [N-1:0] rb;
  logic [3:0]   rop;
  logic [N-1:0] acc;
  logic [N-1:0] t;

  // Sequencer FSM. The ALU drive registers are loaded with the values the
  // *next* state needs, so alu_a/alu_b/alu_op are valid from the first cycle
  // of every state. AH*BL and the shifted partial sum are forwarded straight
  // from alu_y into the operand registers rather than kept in separate copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {N{1'b0}};
      ra     <= {N{1'b0}};
      rb     <= {N{1'b0}};
      rop    <= 4'b0000;
      acc    <= {N{1'b0}};
      t      <= {N{1'b0}};
      alu_a  <= {N{1'b0}};
      alu_b  <= {N{1'b0}};
      alu_op <= ALU_NOP;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            rop   <= op;
            busy  <= 1'b1;
            alu_a <= a;
            alu_b <= b;
            if (op == OP_MUL_FULL) begin
              state  <= M_LL;
              alu_op <= ALU_HMUL;
            end else begin
              state  <= EXEC;
              alu_op <= op;
            end
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            alu_a  <= {N{1'b0}};
            alu_b  <= {N{1'b0}};
            alu_op <= ALU_NOP;
          end
        end
        EXEC: begin
          result <= alu_y;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
          alu_a  <= {N{1'b0}};
          alu_b  <= {N{1'b0}};
          alu_op <= ALU_NOP;
        end
        M_LL: begin
          acc    <= alu_y;
          state  <= M_LH;
          alu_a  <= ra;
          alu_b  <= rb >> H;
          alu_op <= ALU_HMUL;
        end
        M_LH: begin
          t      <= alu_y;
          state  <= M_HL;
          alu_a  <= ra >> H;
          alu_b  <= rb;
          alu_op <= ALU_HMUL;
        end
        M_HL: begin
          state  <= M_ADD1;
          alu_a  <= t;
          alu_b  <= alu_y;
          alu_op <= ALU_ADD;
        end
        M_ADD1: begin
          t      <= alu_y;
          state  <= M_SHL;
          alu_a  <= alu_y;
          alu_b  <= N'(H);
          alu_op <= ALU_SLL;
        end
        M_SHL: begin
          t      <= alu_y;
          state  <= M_ADD2;
          alu_a  <= acc;
          alu_b  <= alu_y;
          alu_op <= ALU_ADD;
        end
        M_ADD2: begin
          result <= alu_y;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
          alu_a  <= {N{1'b0}};
          alu_b  <= {N{1'b0}};
          alu_op <= ALU_NOP;
        end
        default: begin
          busy   <= 1'b0;
          state  <= IDLE;
          alu_a  <= {N{1'b0}};
          alu_b  <= {N{1'b0}};
          alu_op <= ALU_NOP;
        end
      endcase
    end
  end

  alu_mul_sequencer_chk #(.N(N)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .done    (done),
    .in_exec (state == EXEC),
    .rop     (rop),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op)
  );

endmodule

// Protocol properties of the sequencer: done never repeats, IDLE parks the ALU,
// and a pass-through request issues the latched opcode.
module alu_mul_sequencer_chk #(
  parameter int unsigned N = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         busy,
  input logic         done,
  input logic         in_exec,
  input logic [3:0]   rop,
  input logic [N-1:0] alu_a,
  input logic [N-1:0] alu_b,
  input logic [3:0]   alu_op
);

  done_single_cycle: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  done_not_busy:     assert property (@(posedge clk) disable iff (rst) done |-> !busy);
  idle_alu_parked:   assert property (@(posedge clk) disable iff (rst)
                       !busy |-> (alu_op == 4'b0000 && alu_a == {N{1'b0}} && alu_b == {N{1'b0}}));
  exec_issues_rop:   assert property (@(posedge clk) disable iff (rst) in_exec |-> alu_op == rop);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural alu32 model.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;

  int checks = 0;
  int errors = 0;
  int ndone;
  logic [31:0] last_result;
  logic [3:0] mul_seq [6];

  alu_mul_sequencer #(.N(32), .OP_MUL_FULL(4'b0111)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_y  (alu_y)
  );

  // alu32 stand-in: only the opcodes the directed steps use; others return 0.
  always_comb begin
    case (alu_op)
      4'b0100: alu_y = alu_a + alu_b;
      4'b0101: alu_y = alu_a - alu_b;
      4'b0110: alu_y = {16'h0000, alu_a[15:0]} * {16'h0000, alu_b[15:0]};
      4'b1000: alu_y = alu_a | alu_b;
      4'b1100: alu_y = alu_a << alu_b[4:0];
      default: alu_y = 32'h0000_0000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    mul_seq[0] = 4'b0110; mul_seq[1] = 4'b0110; mul_seq[2] = 4'b0110;
    mul_seq[3] = 4'b0100; mul_seq[4] = 4'b1100; mul_seq[5] = 4'b0100;
    rst = 1'b1; start = 1'b0; op = 4'b0000; a = 32'h0; b = 32'h0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_alu_op", {28'h0, alu_op}, 32'h0);

    // 1: single ADD
    start = 1'b1; op = 4'b0100; a = 32'd7; b = 32'd5;
    step();
    start = 1'b0; a = 32'hDEAD_BEEF;
    check("add_busy", {31'h0, busy}, 32'h1);
    check("add_done_early", {31'h0, done}, 32'h0);
    check("add_alu_op", {28'h0, alu_op}, 32'h4);
    check("add_alu_a", alu_a, 32'd7);
    step();
    check("add_done", {31'h0, done}, 32'h1);
    check("add_result", result, 32'd12);
    check("add_idle_busy", {31'h0, busy}, 32'h0);
    check("add_idle_alu_op", {28'h0, alu_op}, 32'h0);
    step();
    check("add_done_drop", {31'h0, done}, 32'h0);
    check("add_result_hold", result, 32'd12);

    // 2: full multiply, opcode sequence
    start = 1'b1; op = 4'b0111; a = 32'h0001_0003; b = 32'h0002_0005;
    step();
    start = 1'b0; a = 32'h0; b = 32'h0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mul_seq_op%0d", i), {28'h0, alu_op}, {28'h0, mul_seq[i]});
      check($sformatf("mul_seq_busy%0d", i), {31'h0, busy}, 32'h1);
      if (i == 4) check("mul_shl_amount", alu_b, 32'd16);
      step();
    end
    check("mul_done", {31'h0, done}, 32'h1);
    check("mul_result", result, 32'h000B_000F);
    check("mul_idle_busy", {31'h0, busy}, 32'h0);

    // 3: all-ones multiply, wraps in both adds
    start = 1'b1; op = 4'b0111; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("wrap_done", {31'h0, done}, 32'h1);
    check("wrap_result", result, 32'h0000_0001);

    // 4: start pulse while busy is ignored
    start = 1'b1; op = 4'b0111; a = 32'h0001_0003; b = 32'h0002_0005;
    step();
    start = 1'b0;
    ndone = 0;
    last_result = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        last_result = result;
      end
      if (i == 2) begin
        start = 1'b1; op = 4'b1010; a = 32'h1234_5678; b = 32'h9;
      end
      if (i == 3) start = 1'b0;
      step();
    end
    check("ignore_done_count", ndone, 32'd1);
    check("ignore_result", last_result, 32'h000B_000F);
    check("ignore_idle", {31'h0, busy}, 32'h0);

    // 5: reset in M_HL aborts
    start = 1'b1; op = 4'b0111; a = 32'h0001_0003; b = 32'h0002_0005;
    step();
    start = 1'b0;
    step();
    step();
    check("abort_in_mhl_alu_a", alu_a, 32'h0000_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort_no_done", ndone, 32'd0);
    start = 1'b1; op = 4'b1000; a = 32'h0000_00F0; b = 32'h0000_000F;
    step();
    start = 1'b0;
    step();
    check("or_done", {31'h0, done}, 32'h1);
    check("or_result", result, 32'h0000_00FF);

    // 6: back-to-back acceptance in the done cycle
    start = 1'b1; op = 4'b0111; a = 32'h0001_0003; b = 32'h0002_0005;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 4'b0101; a = 32'd10; b = 32'd3;
      end
      step();
    end
    check("b2b_mul_done", {31'h0, done}, 32'h1);
    check("b2b_mul_result", result, 32'h000B_000F);
    step();
    start = 1'b0;
    check("b2b_accept_busy", {31'h0, busy}, 32'h1);
    check("b2b_accept_op", {28'h0, alu_op}, 32'h5);
    check("b2b_no_done", {31'h0, done}, 32'h0);
    step();
    check("b2b_sub_done", {31'h0, done}, 32'h1);
    check("b2b_sub_result", result, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that owns the issue port of one shared alu32 instance.
- Single-cycle ALU requests pass through in one ALU pass.
- A full NxN multiply (low N bits of the product) is sequenced from the ALU's native (N/2)x(N/2) multiply (op 0110), ADD (0100) and SLL (1100) passes.
- Sits between the decode/execute control and the combinational alu32. It drives the ALU operands and opcode and registers the ALU output.

Parameters:
N, 32, datapath width; must be even; half width H = N/2.
OP_MUL_FULL, 4'b0111, request opcode that selects the full-width multiply sequence; it is not an ALU opcode.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only while busy=0
op  input  4  requested operation (ALU opcode or OP_MUL_FULL)
a  input  N  operand A
b  input  N  operand B
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse when result is valid
result  output  N  registered result; holds its value until the next done
alu_a  output  N  operand A to alu32
alu_b  output  N  operand B to alu32
alu_op  output  4  opcode to alu32
alu_y  input  N  combinational result from alu32

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, result=0; operand/op/accumulator registers=0.
- Reset mid-sequence aborts the sequence: no done pulse, result=0.
- IDLE outputs: alu_a=0, alu_b=0, alu_op=4'b0000.
- Request acceptance: at an edge with state=IDLE and start=1, latch a, b, op into ra, rb, rop.
  - rop != OP_MUL_FULL: go to EXEC.
  - rop == OP_MUL_FULL: go to M_LL.
- start while busy=1 is ignored. No queueing, no error flag.
- busy=1 in every state except IDLE. busy is registered, so it is high the cycle after acceptance.
- EXEC: drive alu_a=ra, alu_b=rb, alu_op=rop.
  - Next edge: result<=alu_y, done<=1, state<=IDLE.
  - Unsupported opcodes pass through unchanged; alu32 returns 0 for them.
- Full multiply: each state drives the ALU and captures alu_y at the next edge.
  - M_LL: alu_a=ra, alu_b=rb, op 0110 -> acc <= AL*BL.
  - M_LH: alu_a=ra, alu_b=rb>>H, op 0110 -> t <= AL*BH.
  - M_HL: alu_a=ra>>H, alu_b=rb, op 0110 -> u <= AH*BL.
  - M_ADD1: alu_a=t, alu_b=u, op 0100 -> t <= t+u mod 2^N.
  - M_SHL: alu_a=t, alu_b=H, op 1100 -> t <= t<<H.
  - M_ADD2: alu_a=acc, alu_b=t, op 0100 -> result <= alu_y; done<=1; state<=IDLE.
  - All intermediate arithmetic wraps mod 2^N. No overflow or high-half output.
- Latency, counted from the accepting edge to the edge at which done rises:
  - single-op request: 2 edges.
  - full multiply: 7 edges.
- done timing: done is high for exactly one cycle and the state is already IDLE in that cycle. A start present in the done cycle is accepted (back-to-back, no bubble).
- Operands are captured at acceptance. Changes on a/b/op while busy have no effect.

Test Plan:
1. Reset, then start with op=0100, a=7, b=5 -> busy=1 for 1 cycle; done pulses 2 edges after acceptance with result=12; alu_op=0000 again once IDLE.
2. start with op=0111, a=0x0001_0003, b=0x0002_0005 -> done 7 edges later, result=0x000B_000F; ALU opcode sequence 0110,0110,0110,0100,1100,0100.
3. start with op=0111, a=b=0xFFFF_FFFF -> result=0x0000_0001, checking wrap in both ADD passes.
4. Pulse start with op=1010 during cycle 3 of a multiply -> ignored; exactly one done, result matches the multiply only.
5. Assert rst in state M_HL -> next cycle busy=0, done=0, result=0; a following op=1000, a=0xF0, b=0x0F -> result=0xFF.
6. Back-to-back: hold start=1 through the done cycle with op=0101, a=10, b=3 after a multiply -> second request accepted in the done cycle; result=7 two edges later.
